// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling, parity/framing/overrun flags, rdy/clr_rdy handshake.
// Optional UART_RX_FIFO_EN buffers completed words in a FIFO_DEPTH-entry first-word-fall-through FIFO.
module uart_rx_param #(
  parameter int CLK_PER_BIT = 108,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] cmd,
  output logic                 rdy,
  output logic                 par_err,
  output logic                 frm_err,
  output logic                 ovr,
  output logic                 busy
);
  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic             ODD_PAR   = (PARITY_MODE == 2);

  if (CLK_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_rx_param: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic                 sync1_q, rx_s_q;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_pend_q, par_pend_d;
  logic                 frm_pend_q, frm_pend_d;
  logic                 stop_q, stop_d;
  logic                 strobe, done, done_par, done_frm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= RX;
      rx_s_q  <= sync1_q;
    end
  end

  assign strobe   = (state_q != IDLE) && (baud_q == '0);
  assign done_par = par_pend_q;
  // The final stop bit's framing check is folded in combinationally so the word loads on the completing strobe.
  assign done_frm = frm_pend_q | ~rx_s_q;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_pend_q <= 1'b0;
      frm_pend_q <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_pend_q <= par_pend_d;
      frm_pend_q <= frm_pend_d;
      stop_q     <= stop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_pend_d = par_pend_q;
    frm_pend_d = frm_pend_q;
    stop_d     = stop_q;
    done       = 1'b0;
    if (state_q != IDLE) begin
      baud_d = strobe ? FULL_LOAD : baud_q - 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          baud_d  = HALF_LOAD;
        end
      end
      START: begin
        if (strobe) begin
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d    = DATA;
            bit_d      = '0;
            par_pend_d = 1'b0;
            frm_pend_d = 1'b0;
            stop_d     = 1'b0;
          end
        end
      end
      DATA: begin
        if (strobe) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY_MODE != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (strobe) begin
          par_pend_d = ((^shift_q) ^ rx_s_q) != ODD_PAR;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          if (!rx_s_q) frm_pend_d = 1'b1;
          if (stop_q == LAST_STOP) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 perr;
    logic                 ferr;
  } entry_t;

  entry_t      mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        ovr_q, empty, full, pop, push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = clr_rdy && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the completing word.
  assign push  = done && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= '{shift_q, done_par, done_frm};
        wr_q                <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (done && full && !pop) ovr_q <= 1'b1;
      else if (pop && !push)    ovr_q <= 1'b0;
    end
  end

  assign cmd     = mem_q[rd_q[AW-1:0]].data;
  assign par_err = mem_q[rd_q[AW-1:0]].perr;
  assign frm_err = mem_q[rd_q[AW-1:0]].ferr;
  assign rdy     = !empty;
  assign ovr     = ovr_q;
`else
  logic [DATA_BITS-1:0] cmd_q, cmd_d;
  logic                 rdy_q, rdy_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q  <= '0;
      rdy_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      cmd_q  <= cmd_d;
      rdy_q  <= rdy_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ovr_q  <= ovr_d;
    end
  end

  // A completion arriving with the acknowledge in the same cycle replaces the word instead of overrunning.
  always_comb begin
    cmd_d  = cmd_q;
    rdy_d  = rdy_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    ovr_d  = ovr_q;
    if (clr_rdy && rdy_q) begin
      rdy_d  = 1'b0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end
    if (done) begin
      if (rdy_q && !clr_rdy) begin
        ovr_d = 1'b1;
      end else begin
        cmd_d  = shift_q;
        perr_d = done_par;
        ferr_d = done_frm;
        rdy_d  = 1'b1;
      end
    end
  end

  assign cmd     = cmd_q;
  assign rdy     = rdy_q;
  assign par_err = perr_q;
  assign frm_err = ferr_q;
  assign ovr     = ovr_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: three instances (8N1 at 108 clk/bit, 8E1 and 8O2 at 16 clk/bit).
// Frames are driven serially; expected words go into a scoreboard queue and are checked when the DUT presents them.
module tb_uart_rx_param;
  localparam int CPB0 = 108;
  localparam int CPB1 = 16;
  localparam int NV   = 11;

  typedef struct packed {
    logic [7:0] cmd;
    logic       rdy;
    logic       pe;
    logic       fe;
    logic       ovr;
    logic       busy;
  } stat_t;

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       parBit;
    logic       stopLow;
    logic       expPe;
    logic       expFe;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx;
  logic [2:0] clr;
  wire  [7:0] cmdV [3];
  wire  [2:0] rdyV, peV, feV, ovrV, busyV;

  int   checkCount = 0;
  int   passCount  = 0;
  exp_t sb[$];
  vec_t vecs[NV];

  always #5 clk = ~clk;

  uart_rx_param u0 (
    .clk(clk), .rst(rst), .RX(rx[0]), .clr_rdy(clr[0]), .cmd(cmdV[0]), .rdy(rdyV[0]),
    .par_err(peV[0]), .frm_err(feV[0]), .ovr(ovrV[0]), .busy(busyV[0])
  );
  uart_rx_param #(.CLK_PER_BIT(CPB1), .PARITY_MODE(1)) u1 (
    .clk(clk), .rst(rst), .RX(rx[1]), .clr_rdy(clr[1]), .cmd(cmdV[1]), .rdy(rdyV[1]),
    .par_err(peV[1]), .frm_err(feV[1]), .ovr(ovrV[1]), .busy(busyV[1])
  );
  uart_rx_param #(.CLK_PER_BIT(CPB1), .PARITY_MODE(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .RX(rx[2]), .clr_rdy(clr[2]), .cmd(cmdV[2]), .rdy(rdyV[2]),
    .par_err(peV[2]), .frm_err(feV[2]), .ovr(ovrV[2]), .busy(busyV[2])
  );

  function automatic int cpbOf(input int sel);
    return (sel == 0) ? CPB0 : CPB1;
  endfunction

  function automatic stat_t getStat(input int sel);
    return '{cmdV[sel], rdyV[sel], peV[sel], feV[sel], ovrV[sel], busyV[sel]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expectWord(input logic [7:0] data, input logic pe, input logic fe);
    exp_t e;
    e.data = data;
    e.pe   = pe;
    e.fe   = fe;
    sb.push_back(e);
  endtask

  // A low final stop bit is held only across the sample point so the line is high again before IDLE looks at it.
  task automatic applyStimulus(input int sel, input logic [7:0] data, input logic parBit, input logic stopLow);
    int cpb   = cpbOf(sel);
    int nStop = (sel == 2) ? 2 : 1;
    rx[sel] = 1'b0;
    repeat (cpb) tick();
    for (int i = 0; i < 8; i++) begin
      rx[sel] = data[i];
      repeat (cpb) tick();
    end
    if (sel != 0) begin
      rx[sel] = parBit;
      repeat (cpb) tick();
    end
    for (int s = 0; s < nStop; s++) begin
      rx[sel] = !(stopLow && s == nStop - 1);
      repeat (cpb / 2 + 1) tick();
      rx[sel] = 1'b1;
      repeat (cpb - cpb / 2 - 1) tick();
    end
  endtask

  task automatic popAndCheck(input int sel);
    int    n = 0;
    exp_t  e;
    stat_t s;
    while (!rdyV[sel] && n < 20 * cpbOf(sel)) begin
      tick();
      n++;
    end
    checkOutput("rdy_wait", rdyV[sel], 1'b1);
    checkOutput("sb_has_entry", sb.size() > 0, 1'b1);
    if (rdyV[sel] && sb.size() > 0) begin
      e = sb.pop_front();
      s = getStat(sel);
      checkOutput("cmd", s.cmd, e.data);
      checkOutput("par_err", s.pe, e.pe);
      checkOutput("frm_err", s.fe, e.fe);
    end
    clr[sel] = 1'b1;
    tick();
    clr[sel] = 1'b0;
  endtask

  initial begin
    int lat;
    vecs[0]  = '{0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{2, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{2, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{2, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    rx  = 3'b111;
    clr = 3'b000;
    repeat (2) tick();
    for (int s = 0; s < 3; s++) checkOutput($sformatf("reset_state_%0d", s), getStat(s), '0);
    rst = 1'b0;
    repeat (5) tick();

    $display("[TB] 8N1 latency and handshake");
    expectWord(8'hA5, 1'b0, 1'b0);
    lat = 0;
    fork
      applyStimulus(0, 8'hA5, 1'b0, 1'b0);
      begin
        while (!rdyV[0] && lat < 1200) begin
          tick();
          lat++;
        end
      end
    join
    checkOutput("latency", lat, 3 + CPB0 / 2 + 9 * CPB0);
    popAndCheck(0);
    checkOutput("rdy_after_clr", rdyV[0], 1'b0);
`ifndef UART_RX_FIFO_EN
    checkOutput("cmd_held", cmdV[0], 8'hA5);
`endif

    $display("[TB] false start");
    rx[0] = 1'b0;
    repeat (20) tick();
    checkOutput("busy_in_start", busyV[0], 1'b1);
    repeat (20) tick();
    rx[0] = 1'b1;
    repeat (60) tick();
    checkOutput("busy_after_false", busyV[0], 1'b0);
    checkOutput("flags_after_false", {rdyV[0], peV[0], feV[0], ovrV[0]}, 4'b0000);

    $display("[TB] vector table");
    for (int i = 0; i < NV; i++) begin
      expectWord(vecs[i].data, vecs[i].expPe, vecs[i].expFe);
      applyStimulus(vecs[i].sel, vecs[i].data, vecs[i].parBit, vecs[i].stopLow);
      popAndCheck(vecs[i].sel);
      checkOutput($sformatf("rdy_cleared_%0d", i), rdyV[vecs[i].sel], 1'b0);
      checkOutput($sformatf("flags_cleared_%0d", i), {peV[vecs[i].sel], feV[vecs[i].sel]}, 2'b00);
      repeat (4) tick();
    end

    $display("[TB] overrun");
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) expectWord(8'(i * 8'h11), 1'b0, 1'b0);
      applyStimulus(0, 8'(i * 8'h11), 1'b0, 1'b0);
    end
    checkOutput("ovr_set", ovrV[0], 1'b1);
    for (int i = 0; i < 4; i++) popAndCheck(0);
    checkOutput("ovr_cleared", ovrV[0], 1'b0);
    checkOutput("fifo_drained", rdyV[0], 1'b0);
`else
    expectWord(8'h11, 1'b0, 1'b0);
    applyStimulus(0, 8'h11, 1'b0, 1'b0);
    applyStimulus(0, 8'h22, 1'b0, 1'b0);
    checkOutput("ovr_set", ovrV[0], 1'b1);
    checkOutput("cmd_retained", cmdV[0], 8'h11);
    popAndCheck(0);
    checkOutput("ovr_cleared", ovrV[0], 1'b0);
`endif

    $display("[TB] reset mid-frame");
    rx[0] = 1'b0;
    repeat (5 * CPB0 + CPB0 / 2) tick();
    checkOutput("busy_midframe", busyV[0], 1'b1);
    rst   = 1'b1;
    rx[0] = 1'b1;
    tick();
    checkOutput("reset_midframe", getStat(0), '0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    checkOutput("no_partial_word", rdyV[0], 1'b0);
    expectWord(8'h3C, 1'b0, 1'b0);
    applyStimulus(0, 8'h3C, 1'b0, 1'b0);
    popAndCheck(0);

    checkOutput("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
